// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register.
//   usr_mode_e : the 3-bit operation codes carried on the mode port.
//   usr_sel_e  : the per-bit next-value select used by every usr_cell.
//   is_shift() : true for the four modes that advance the bit counter.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHR   = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_ROR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } usr_mode_e;

  // SEL_LEFT takes the left (more significant) neighbour, so it serves
  // SHR and ROR. SEL_RIGHT takes the right (less significant) neighbour,
  // so it serves SHL and ROL.
  typedef enum logic [2:0] {
    SEL_HOLD  = 3'd0,
    SEL_LEFT  = 3'd1,
    SEL_RIGHT = 3'd2,
    SEL_LOAD  = 3'd3,
    SEL_ZERO  = 3'd4
  } usr_sel_e;

  function automatic logic is_shift(input usr_mode_e m);
    return (m == MODE_SHR) || (m == MODE_SHL) ||
           (m == MODE_ROR) || (m == MODE_ROL);
  endfunction

endpackage

// File: rtl/usr_cell.sv
// One bit of the universal shift register.
// Ports:
//   cl    : clock, rising edge
//   r     : synchronous active-high reset, clears the bit
//   sel   : next-value select shared by all cells
//   left  : value of the more significant neighbour (or serial/rotate source)
//   right : value of the less significant neighbour (or serial/rotate source)
//   load  : parallel load data for this bit
//   q     : stored bit
module usr_cell
  import usr_pkg::*;
(
  input  logic     cl,
  input  logic     r,
  input  usr_sel_e sel,
  input  logic     left,
  input  logic     right,
  input  logic     load,
  output logic     q
);

  logic d;

  always_comb begin
    d = q;
    unique case (sel)
      SEL_LEFT:  d = left;
      SEL_RIGHT: d = right;
      SEL_LOAD:  d = load;
      SEL_ZERO:  d = 1'b0;
      default:   d = q;
    endcase
  end

  always_ff @(posedge cl) begin
    if (r) q <= 1'b0;
    else   q <= d;
  end

endmodule

// File: rtl/univ_shift_register.sv
// Universal shift register: hold, shift right/left with serial input,
// rotate right/left, parallel load and clear, one cycle latency.
// A counter tracks shifts since the last frame start (LOAD, CLEAR or reset)
// and frame_done pulses for one cycle on the edge completing WIDTH shifts.
// Ports:
//   cl         : clock, all state updates on the rising edge
//   r          : synchronous active-high reset
//   mode       : operation select (usr_mode_e encoding)
//   sin_r      : serial input entering the MSB on SHR
//   sin_l      : serial input entering the LSB on SHL
//   pin        : parallel load data
//   parout     : register contents
//   sout_lsb   : parout[0]
//   sout_msb   : parout[WIDTH-1]
//   bit_cnt    : shifts since the last frame start
//   frame_done : registered one-cycle pulse at the end of each frame
module univ_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             cl,
  input  logic             r,
  input  logic [2:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] parout,
  output logic             sout_lsb,
  output logic             sout_msb,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_done
);

  usr_mode_e        mode_e;
  usr_sel_e         sel;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] left_src;
  logic [WIDTH-1:0] right_src;
  logic             msb_in;
  logic             lsb_in;

  assign mode_e = usr_mode_e'(mode);

  always_comb begin
    sel = SEL_HOLD;
    unique case (mode_e)
      MODE_SHR, MODE_ROR: sel = SEL_LEFT;
      MODE_SHL, MODE_ROL: sel = SEL_RIGHT;
      MODE_LOAD:          sel = SEL_LOAD;
      MODE_CLEAR:         sel = SEL_ZERO;
      default:            sel = SEL_HOLD;
    endcase
  end

  // The end cells pick up either the serial input or the opposite end,
  // depending on whether the operation is a shift or a rotate.
  assign msb_in    = (mode_e == MODE_ROR) ? q[0]       : sin_r;
  assign lsb_in    = (mode_e == MODE_ROL) ? q[WIDTH-1] : sin_l;
  assign left_src  = {msb_in, q[WIDTH-1:1]};
  assign right_src = {q[WIDTH-2:0], lsb_in};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    usr_cell u_cell (
      .cl    (cl),
      .r     (r),
      .sel   (sel),
      .left  (left_src[i]),
      .right (right_src[i]),
      .load  (pin[i]),
      .q     (q[i])
    );
  end

  // Frame counter: shifts advance it, LOAD/CLEAR restart the frame,
  // everything else leaves it alone. frame_done is only ever a single-edge pulse.
  always_ff @(posedge cl) begin
    if (r) begin
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else if (is_shift(mode_e)) begin
      if (bit_cnt == CNT_W'(WIDTH - 1)) begin
        bit_cnt    <= '0;
        frame_done <= 1'b1;
      end else begin
        bit_cnt    <= bit_cnt + CNT_W'(1);
        frame_done <= 1'b0;
      end
    end else if (mode_e == MODE_LOAD || mode_e == MODE_CLEAR) begin
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
    end
  end

  assign parout   = q;
  assign sout_lsb = q[0];
  assign sout_msb = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_register.sv
// Bench for univ_shift_register: an 8-bit and a 16-bit instance share one
// stimulus stream and are each compared against an arithmetic reference model.
module tb_univ_shift_register;

  localparam logic [2:0] M_HOLD  = 3'd0;
  localparam logic [2:0] M_SHR   = 3'd1;
  localparam logic [2:0] M_SHL   = 3'd2;
  localparam logic [2:0] M_ROR   = 3'd3;
  localparam logic [2:0] M_ROL   = 3'd4;
  localparam logic [2:0] M_LOAD  = 3'd5;
  localparam logic [2:0] M_CLEAR = 3'd6;
  localparam logic [2:0] M_RSVD  = 3'd7;

  // clock / reset
  logic cl = 1'b0;
  always #5 cl = ~cl;

  logic        r;
  logic [2:0]  mode;
  logic        sin_r;
  logic        sin_l;
  logic [7:0]  pin8;
  logic [15:0] pin16;

  logic [7:0]  par8;
  logic        lsb8, msb8, fd8;
  logic [2:0]  cnt8;
  logic [15:0] par16;
  logic        lsb16, msb16, fd16;
  logic [3:0]  cnt16;

  univ_shift_register #(.WIDTH(8)) dut8 (
    .cl(cl), .r(r), .mode(mode), .sin_r(sin_r), .sin_l(sin_l), .pin(pin8),
    .parout(par8), .sout_lsb(lsb8), .sout_msb(msb8), .bit_cnt(cnt8),
    .frame_done(fd8)
  );

  univ_shift_register #(.WIDTH(16)) dut16 (
    .cl(cl), .r(r), .mode(mode), .sin_r(sin_r), .sin_l(sin_l), .pin(pin16),
    .parout(par16), .sout_lsb(lsb16), .sout_msb(msb16), .bit_cnt(cnt16),
    .frame_done(fd16)
  );

  // scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] m8, m16;
  int          c8, c16;
  bit          f8, f16;

  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: register as an integer, frame position as shifts mod w.
  task automatic model_step(input int w, input logic [2:0] md, input logic sr,
                            input logic sl, input logic [63:0] p, input logic rst,
                            inout logic [63:0] v, inout int c, output bit f);
    logic [63:0] mask;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    f = 1'b0;
    if (rst) begin
      v = '0;
      c = 0;
    end else begin
      case (md)
        M_SHR: v = (v >> 1) | (64'(sr) << (w - 1));
        M_SHL: v = ((v << 1) | 64'(sl)) & mask;
        M_ROR: v = (v >> 1) | ((v & 64'd1) << (w - 1));
        M_ROL: v = ((v << 1) | (v >> (w - 1))) & mask;
        M_LOAD: v = p & mask;
        M_CLEAR: v = '0;
        default: ;
      endcase
      if (md >= M_SHR && md <= M_ROL) begin
        c = (c + 1) % w;
        f = (c == 0);
      end else if (md == M_LOAD || md == M_CLEAR) begin
        c = 0;
      end
    end
  endtask

  // driver: apply one cycle of inputs, advance the model, compare after the edge
  task automatic do_edge(input logic [2:0] md, input logic sr, input logic sl,
                         input logic [15:0] p, input logic rst);
    r = rst; mode = md; sin_r = sr; sin_l = sl; pin8 = p[7:0]; pin16 = p;
    model_step(8, md, sr, sl, {48'd0, p}, rst, m8, c8, f8);
    exp_q.push_back(m8);
    model_step(16, md, sr, sl, {48'd0, p}, rst, m16, c16, f16);
    exp_q.push_back(m16);
    @(posedge cl);
    #1;
    check_eq("par8", par8, exp_q.pop_front());
    check_eq("lsb8", lsb8, m8[0]);
    check_eq("msb8", msb8, m8[7]);
    check_eq("cnt8", cnt8, c8);
    check_eq("fd8", fd8, f8);
    check_eq("par16", par16, exp_q.pop_front());
    check_eq("lsb16", lsb16, m16[0]);
    check_eq("msb16", msb16, m16[15]);
    check_eq("cnt16", cnt16, c16);
    check_eq("fd16", fd16, f16);
  endtask

  initial begin
    logic [7:0] sbits;
    logic [7:0] held;
    int         nfd;
    m8 = '0; m16 = '0; c8 = 0; c16 = 0; f8 = 0; f16 = 0;
    r = 1'b1; mode = M_HOLD; sin_r = 1'b0; sin_l = 1'b0; pin8 = '0; pin16 = '0;

    // reset with LOAD of all ones still clears
    do_edge(M_LOAD, 1'b0, 1'b0, 16'hFFFF, 1'b1);
    check_eq("rst_par", par8, 8'h00);
    check_eq("rst_cnt", cnt8, 3'd0);
    check_eq("rst_fd", fd8, 1'b0);

    // serial-in frame: 1,0,1,1,0,0,1,0 shifted right gives 8'h4D
    sbits = 8'b0100_1101;
    do_edge(M_CLEAR, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      do_edge(M_SHR, sbits[i], 1'b1, 16'($urandom), 1'b0);
      check_eq("frame8_fd", fd8, (i == 7));
      check_eq("frame16_fd_early", fd16, 1'b0);
    end
    check_eq("frame8_par", par8, 8'h4D);
    check_eq("frame8_cnt", cnt8, 3'd0);
    // 16-bit instance completes its frame after 8 more shifts
    for (int i = 0; i < 8; i++) begin
      do_edge(M_SHR, sbits[i], 1'b0, 16'h0, 1'b0);
      check_eq("frame16_fd", fd16, (i == 7));
    end
    check_eq("frame16_par", par16, 16'h4D4D);

    // rotate
    do_edge(M_LOAD, 1'b0, 1'b0, 16'h0081, 1'b0);
    do_edge(M_ROL, 1'b1, 1'b1, 16'h0, 1'b0);
    check_eq("rol_par", par8, 8'h03);
    do_edge(M_ROR, 1'b0, 1'b0, 16'h0, 1'b0);
    do_edge(M_ROR, 1'b0, 1'b0, 16'h0, 1'b0);
    check_eq("ror_par", par8, 8'hC0);
    check_eq("ror_msb", msb8, 1'b1);
    check_eq("ror_lsb", lsb8, 1'b0);

    // hold keeps the count, LOAD restarts the frame
    do_edge(M_LOAD, 1'b0, 1'b0, 16'h5A5A, 1'b0);
    for (int i = 0; i < 5; i++) do_edge(M_SHL, 1'($urandom), 1'($urandom), 16'h0, 1'b0);
    check_eq("shl5_cnt", cnt8, 3'd5);
    for (int i = 0; i < 3; i++) do_edge(M_HOLD, 1'($urandom), 1'($urandom), 16'h0, 1'b0);
    check_eq("hold_cnt", cnt8, 3'd5);
    do_edge(M_LOAD, 1'b0, 1'b0, 16'h1234, 1'b0);
    check_eq("load_cnt", cnt8, 3'd0);
    for (int i = 0; i < 8; i++) begin
      do_edge(M_SHL, 1'b0, 1'($urandom), 16'h0, 1'b0);
      check_eq("restart_fd", fd8, (i == 7));
    end

    // reset mid-frame
    for (int i = 0; i < 6; i++) do_edge(M_SHR, 1'($urandom), 1'b0, 16'h0, 1'b0);
    do_edge(M_SHR, 1'b1, 1'b1, 16'h0, 1'b1);
    check_eq("midrst_cnt", cnt8, 3'd0);
    nfd = 0;
    for (int i = 0; i < 8; i++) begin
      do_edge(M_SHR, 1'($urandom), 1'b0, 16'h0, 1'b0);
      if (fd8) nfd++;
      check_eq("midrst_fd", fd8, (i == 7));
    end
    check_eq("midrst_fd_once", nfd, 1);

    // reserved mode holds value and count
    do_edge(M_LOAD, 1'b0, 1'b0, 16'hC3A5, 1'b0);
    do_edge(M_SHL, 1'b0, 1'b1, 16'h0, 1'b0);
    held = par8;
    for (int i = 0; i < 3; i++) do_edge(M_RSVD, 1'($urandom), 1'($urandom), 16'($urandom), 1'b0);
    check_eq("rsvd_par", par8, held);
    check_eq("rsvd_cnt", cnt8, 3'd1);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      do_edge(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 16'($urandom),
              ($urandom_range(0, 39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
